// File: rtl/controller_pkg.sv
// Shared encodings, state type and control-word bundle for the stepper-motor
// processor control unit.
package controller_pkg;

  // Controller states. Values are fixed so that waveforms stay stable.
  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_MOVE_CHECK = 3'd2,
    ST_MOVE_WAIT  = 3'd3,
    ST_PAUSE_WAIT = 3'd4,
    ST_HALT       = 3'd5
  } state_e;

  // ALU operand 1 source.
  localparam logic [1:0] OP1_PC       = 2'b00;
  localparam logic [1:0] OP1_REG      = 2'b01;
  localparam logic [1:0] OP1_R0       = 2'b10;
  localparam logic [1:0] OP1_POSITION = 2'b11;

  // ALU operand 2 source.
  localparam logic [1:0] OP2_REG  = 2'b00;
  localparam logic [1:0] OP2_IMM  = 2'b01;
  localparam logic [1:0] OP2_ZERO = 2'b10;

  // Immediate source. The nibble instructions read the same instruction
  // immediate field as addi/subi (the ALU set_low/set_high modes place the
  // nibble), so IMM_NIBBLE shares its code with IMM_ARITH. This frees two
  // codes for the two motor step sizes.
  localparam logic [1:0] IMM_BRANCH = 2'b00;
  localparam logic [1:0] IMM_ARITH  = 2'b01;
  localparam logic [1:0] IMM_NIBBLE = 2'b01;
  localparam logic [1:0] IMM_STEP1  = 2'b10;
  localparam logic [1:0] IMM_STEP2  = 2'b11;

  // Register-file write address source.
  localparam logic [1:0] WA_FIELD0   = 2'b00;
  localparam logic [1:0] WA_FIELD1   = 2'b01;
  localparam logic [1:0] WA_R0       = 2'b10;
  localparam logic [1:0] WA_POSITION = 2'b11;

  // ALU add/sub select.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam int NUM_FLAGS = 12;

  // Every datapath control signal, bundled so that each control source
  // (decode, move sequencer) can build a word starting from all zeros.
  typedef struct packed {
    logic       write_reg_file;
    logic       result_mux_select;
    logic [1:0] op1_mux_select;
    logic [1:0] op2_mux_select;
    logic       start_delay_counter;
    logic       enable_delay_counter;
    logic       commit_branch;
    logic       increment_pc;
    logic       alu_add_sub;
    logic       alu_set_low;
    logic       alu_set_high;
    logic       load_temp;
    logic       increment_temp;
    logic       decrement_temp;
    logic [1:0] select_immediate;
    logic [1:0] select_write_address;
  } ctrl_t;

  // True when exactly one decoder flag is set.
  function automatic logic is_one_hot(input logic [NUM_FLAGS-1:0] f);
    return (f != '0) && ((f & (f - NUM_FLAGS'(1))) == '0);
  endfunction

endpackage

// File: rtl/move_sequencer.sv
// Step loop for movr/movrhs: holds the step size chosen at decode and
// produces the control word and state hints for MOVE_CHECK / MOVE_WAIT.
module move_sequencer
  import controller_pkg::*;
#(
  parameter int FULL_STEP = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load_step,
  input  logic  half_step,
  input  logic  in_check,
  input  logic  in_wait,
  input  logic  temp_is_positive,
  input  logic  temp_is_negative,
  input  logic  temp_is_zero,
  input  logic  delay_done,
  output ctrl_t ctrl,
  output logic  go_wait,
  output logic  go_check,
  output logic  go_fetch
);

  localparam logic [1:0] FULL_STEP_SIZE = 2'(FULL_STEP);

  logic [1:0] step_size;

  // Latch the step size when a move instruction is decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_size <= FULL_STEP_SIZE;
    end else if (load_step) begin
      step_size <= half_step ? 2'd1 : FULL_STEP_SIZE;
    end
  end

  // One position update per MOVE_CHECK visit, then wait on the delay counter.
  always_comb begin
    ctrl     = '0;
    go_wait  = 1'b0;
    go_check = 1'b0;
    go_fetch = 1'b0;
    if (in_check) begin
      if (temp_is_zero) begin
        ctrl.increment_pc = 1'b1;
        go_fetch          = 1'b1;
      end else if (temp_is_positive || temp_is_negative) begin
        ctrl.op1_mux_select       = OP1_POSITION;
        ctrl.op2_mux_select       = OP2_IMM;
        ctrl.select_immediate     = (step_size == 2'd1) ? IMM_STEP1 : IMM_STEP2;
        ctrl.alu_add_sub          = temp_is_positive ? ALU_ADD : ALU_SUB;
        ctrl.select_write_address = WA_POSITION;
        ctrl.write_reg_file       = 1'b1;
        // Positive wins if both signs are ever reported, so only one of the
        // temp adjust strobes can fire.
        ctrl.decrement_temp       = temp_is_positive;
        ctrl.increment_temp       = !temp_is_positive;
        ctrl.start_delay_counter  = 1'b1;
        go_wait                   = 1'b1;
      end
    end else if (in_wait) begin
      ctrl.enable_delay_counter = 1'b1;
      go_check                  = delay_done;
    end
  end

endmodule

// File: rtl/datapath_controller.sv
// Control unit for the stepper-motor processor: fetch/decode FSM and the
// datapath control word. Move loops are delegated to move_sequencer.
module datapath_controller
  import controller_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0,
  parameter int FULL_STEP    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       br,
  input  logic       brz,
  input  logic       addi,
  input  logic       subi,
  input  logic       sr0,
  input  logic       srh0,
  input  logic       clr,
  input  logic       mov,
  input  logic       mova,
  input  logic       movr,
  input  logic       movrhs,
  input  logic       pause,
  input  logic       delay_done,
  input  logic       temp_is_positive,
  input  logic       temp_is_negative,
  input  logic       temp_is_zero,
  input  logic       register0_is_zero,
  output logic       write_reg_file,
  output logic       result_mux_select,
  output logic [1:0] op1_mux_select,
  output logic [1:0] op2_mux_select,
  output logic       start_delay_counter,
  output logic       enable_delay_counter,
  output logic       commit_branch,
  output logic       increment_pc,
  output logic       alu_add_sub,
  output logic       alu_set_low,
  output logic       alu_set_high,
  output logic       load_temp,
  output logic       increment_temp,
  output logic       decrement_temp,
  output logic [1:0] select_immediate,
  output logic [1:0] select_write_address,
  output logic       halted
);

  // Handshake note: there is no valid/ready pairing here. Decoder flags are
  // qualified by the DECODE state, and delay_done is qualified by the two
  // WAIT states; a flag seen in any other state is ignored.

  state_e               state;
  state_e               next_state;
  logic [NUM_FLAGS-1:0] flags;
  logic                 legal;
  ctrl_t                dec_ctrl;
  ctrl_t                seq_ctrl;
  ctrl_t                ctrl;
  logic                 seq_go_wait;
  logic                 seq_go_check;
  logic                 seq_go_fetch;

  assign flags = {br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause};
  assign legal = is_one_hot(flags);

  move_sequencer #(
    .FULL_STEP(FULL_STEP)
  ) u_move_sequencer (
    .clk              (clk),
    .reset            (reset),
    .load_step        ((state == ST_DECODE) && legal && (movr || movrhs)),
    .half_step        (movrhs),
    .in_check         (state == ST_MOVE_CHECK),
    .in_wait          (state == ST_MOVE_WAIT),
    .temp_is_positive (temp_is_positive),
    .temp_is_negative (temp_is_negative),
    .temp_is_zero     (temp_is_zero),
    .delay_done       (delay_done),
    .ctrl             (seq_ctrl),
    .go_wait          (seq_go_wait),
    .go_check         (seq_go_check),
    .go_fetch         (seq_go_fetch)
  );

  // State register; reset aborts any fetch, move or pause in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the control word for the non-move states.
  always_comb begin
    next_state = state;
    dec_ctrl   = '0;
    case (state)
      ST_FETCH: begin
        // Instruction ROM latency cycle: nothing driven.
        next_state = ST_DECODE;
      end
      ST_DECODE: begin
        next_state = ST_FETCH;
        if (!legal) begin
          if (ILLEGAL_HALT) begin
            next_state = ST_HALT;
          end else begin
            dec_ctrl.increment_pc = 1'b1;
          end
        end else if (br || (brz && register0_is_zero)) begin
          dec_ctrl.op1_mux_select   = OP1_PC;
          dec_ctrl.op2_mux_select   = OP2_IMM;
          dec_ctrl.select_immediate = IMM_BRANCH;
          dec_ctrl.alu_add_sub      = ALU_ADD;
          dec_ctrl.commit_branch    = 1'b1;
        end else if (brz) begin
          dec_ctrl.increment_pc = 1'b1;
        end else if (addi || subi) begin
          dec_ctrl.op1_mux_select       = OP1_REG;
          dec_ctrl.op2_mux_select       = OP2_IMM;
          dec_ctrl.select_immediate     = IMM_ARITH;
          dec_ctrl.alu_add_sub          = subi ? ALU_SUB : ALU_ADD;
          dec_ctrl.select_write_address = WA_FIELD0;
          dec_ctrl.write_reg_file       = 1'b1;
          dec_ctrl.increment_pc         = 1'b1;
        end else if (sr0 || srh0) begin
          dec_ctrl.op1_mux_select       = OP1_R0;
          dec_ctrl.op2_mux_select       = OP2_IMM;
          dec_ctrl.select_immediate     = IMM_NIBBLE;
          dec_ctrl.alu_set_low          = sr0;
          dec_ctrl.alu_set_high         = srh0;
          dec_ctrl.select_write_address = WA_R0;
          dec_ctrl.write_reg_file       = 1'b1;
          dec_ctrl.increment_pc         = 1'b1;
        end else if (clr) begin
          dec_ctrl.op1_mux_select       = OP1_REG;
          dec_ctrl.op2_mux_select       = OP2_ZERO;
          dec_ctrl.alu_set_low          = 1'b1;
          dec_ctrl.alu_set_high         = 1'b1;
          dec_ctrl.select_write_address = WA_FIELD0;
          dec_ctrl.write_reg_file       = 1'b1;
          dec_ctrl.increment_pc         = 1'b1;
        end else if (mov) begin
          dec_ctrl.op1_mux_select       = OP1_REG;
          dec_ctrl.op2_mux_select       = OP2_ZERO;
          dec_ctrl.alu_add_sub          = ALU_ADD;
          dec_ctrl.select_write_address = WA_FIELD1;
          dec_ctrl.write_reg_file       = 1'b1;
          dec_ctrl.increment_pc         = 1'b1;
        end else if (mova) begin
          // Absolute move: write position, then settle for one delay period.
          dec_ctrl.op1_mux_select       = OP1_REG;
          dec_ctrl.op2_mux_select       = OP2_ZERO;
          dec_ctrl.alu_add_sub          = ALU_ADD;
          dec_ctrl.select_write_address = WA_POSITION;
          dec_ctrl.write_reg_file       = 1'b1;
          dec_ctrl.start_delay_counter  = 1'b1;
          next_state                    = ST_PAUSE_WAIT;
        end else if (movr || movrhs) begin
          dec_ctrl.load_temp = 1'b1;
          next_state         = ST_MOVE_CHECK;
        end else begin
          // Only pause remains once the flags are known to be one-hot.
          dec_ctrl.start_delay_counter = 1'b1;
          next_state                   = ST_PAUSE_WAIT;
        end
      end
      ST_MOVE_CHECK: begin
        if (seq_go_fetch) begin
          next_state = ST_FETCH;
        end else if (seq_go_wait) begin
          next_state = ST_MOVE_WAIT;
        end
      end
      ST_MOVE_WAIT: begin
        if (seq_go_check) begin
          next_state = ST_MOVE_CHECK;
        end
      end
      ST_PAUSE_WAIT: begin
        dec_ctrl.enable_delay_counter = 1'b1;
        if (delay_done) begin
          dec_ctrl.increment_pc = 1'b1;
          next_state            = ST_FETCH;
        end
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_FETCH;
      end
    endcase
  end

  // Select the active control word; reset forces it quiet so nothing pulses
  // during the reset cycle.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      if ((state == ST_MOVE_CHECK) || (state == ST_MOVE_WAIT)) begin
        ctrl = seq_ctrl;
      end else begin
        ctrl = dec_ctrl;
      end
    end
  end

  assign write_reg_file       = ctrl.write_reg_file;
  assign result_mux_select    = ctrl.result_mux_select;
  assign op1_mux_select       = ctrl.op1_mux_select;
  assign op2_mux_select       = ctrl.op2_mux_select;
  assign start_delay_counter  = ctrl.start_delay_counter;
  assign enable_delay_counter = ctrl.enable_delay_counter;
  assign commit_branch        = ctrl.commit_branch;
  assign increment_pc         = ctrl.increment_pc;
  assign alu_add_sub          = ctrl.alu_add_sub;
  assign alu_set_low          = ctrl.alu_set_low;
  assign alu_set_high         = ctrl.alu_set_high;
  assign load_temp            = ctrl.load_temp;
  assign increment_temp       = ctrl.increment_temp;
  assign decrement_temp       = ctrl.decrement_temp;
  assign select_immediate     = ctrl.select_immediate;
  assign select_write_address = ctrl.select_write_address;
  assign halted               = (state == ST_HALT) && !reset;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller. Two instances share all inputs:
// dut treats illegal decodes as NOP, dut_h halts on them.
module tb_datapath_controller;

  // Encodings as the datapath expects them.
  localparam logic [1:0] OP1_PC = 2'b00, OP1_REG = 2'b01, OP1_R0 = 2'b10, OP1_POS = 2'b11;
  localparam logic [1:0] OP2_IMM = 2'b01, OP2_ZERO = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b00, IMM_ARITH = 2'b01, IMM_NIBBLE = 2'b01;
  localparam logic [1:0] IMM_STEP1 = 2'b10, IMM_STEP2 = 2'b11;
  localparam logic [1:0] WA_FIELD0 = 2'b00, WA_FIELD1 = 2'b01, WA_R0 = 2'b10, WA_POS = 2'b11;
  localparam logic ADD = 1'b0, SUB = 1'b1;

  // Flag vector bits: {br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause}
  localparam logic [11:0] FL_BR = 12'h800, FL_BRZ = 12'h400, FL_ADDI = 12'h200, FL_SUBI = 12'h100;
  localparam logic [11:0] FL_SR0 = 12'h080, FL_SRH0 = 12'h040, FL_CLR = 12'h020, FL_MOV = 12'h010;
  localparam logic [11:0] FL_MOVA = 12'h008, FL_MOVR = 12'h004, FL_MOVRHS = 12'h002, FL_PAUSE = 12'h001;

  // Delay counter model: done is seen this many WAIT cycles after a start.
  localparam int WAIT_CYCLES = 4;

  localparam logic [20:0] ZERO_VEC   = 21'h0;
  localparam logic [20:0] HALTED_VEC = 21'h1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] flags = 12'h0;
  logic delay_done = 1'b0, temp_is_positive = 1'b0, temp_is_negative = 1'b0;
  logic temp_is_zero = 1'b1, register0_is_zero = 1'b0;

  logic       write_reg_file, result_mux_select, start_delay_counter, enable_delay_counter;
  logic       commit_branch, increment_pc, alu_add_sub, alu_set_low, alu_set_high;
  logic       load_temp, increment_temp, decrement_temp, halted;
  logic [1:0] op1_mux_select, op2_mux_select, select_immediate, select_write_address;

  logic       h_write_reg_file, h_result_mux_select, h_start_delay_counter, h_enable_delay_counter;
  logic       h_commit_branch, h_increment_pc, h_alu_add_sub, h_alu_set_low, h_alu_set_high;
  logic       h_load_temp, h_increment_temp, h_decrement_temp, h_halted;
  logic [1:0] h_op1_mux_select, h_op2_mux_select, h_select_immediate, h_select_write_address;

  logic [20:0] outs, h_outs;
  assign outs = {write_reg_file, result_mux_select, op1_mux_select, op2_mux_select,
                 start_delay_counter, enable_delay_counter, commit_branch, increment_pc,
                 alu_add_sub, alu_set_low, alu_set_high, load_temp, increment_temp,
                 decrement_temp, select_immediate, select_write_address, halted};
  assign h_outs = {h_write_reg_file, h_result_mux_select, h_op1_mux_select, h_op2_mux_select,
                   h_start_delay_counter, h_enable_delay_counter, h_commit_branch, h_increment_pc,
                   h_alu_add_sub, h_alu_set_low, h_alu_set_high, h_load_temp, h_increment_temp,
                   h_decrement_temp, h_select_immediate, h_select_write_address, h_halted};

  datapath_controller #(.ILLEGAL_HALT(1'b0), .FULL_STEP(2)) dut (
    .clk(clk), .reset(reset),
    .br(flags[11]), .brz(flags[10]), .addi(flags[9]), .subi(flags[8]), .sr0(flags[7]),
    .srh0(flags[6]), .clr(flags[5]), .mov(flags[4]), .mova(flags[3]), .movr(flags[2]),
    .movrhs(flags[1]), .pause(flags[0]),
    .delay_done(delay_done), .temp_is_positive(temp_is_positive),
    .temp_is_negative(temp_is_negative), .temp_is_zero(temp_is_zero),
    .register0_is_zero(register0_is_zero),
    .write_reg_file(write_reg_file), .result_mux_select(result_mux_select),
    .op1_mux_select(op1_mux_select), .op2_mux_select(op2_mux_select),
    .start_delay_counter(start_delay_counter), .enable_delay_counter(enable_delay_counter),
    .commit_branch(commit_branch), .increment_pc(increment_pc), .alu_add_sub(alu_add_sub),
    .alu_set_low(alu_set_low), .alu_set_high(alu_set_high), .load_temp(load_temp),
    .increment_temp(increment_temp), .decrement_temp(decrement_temp),
    .select_immediate(select_immediate), .select_write_address(select_write_address),
    .halted(halted)
  );

  datapath_controller #(.ILLEGAL_HALT(1'b1), .FULL_STEP(2)) dut_h (
    .clk(clk), .reset(reset),
    .br(flags[11]), .brz(flags[10]), .addi(flags[9]), .subi(flags[8]), .sr0(flags[7]),
    .srh0(flags[6]), .clr(flags[5]), .mov(flags[4]), .mova(flags[3]), .movr(flags[2]),
    .movrhs(flags[1]), .pause(flags[0]),
    .delay_done(delay_done), .temp_is_positive(temp_is_positive),
    .temp_is_negative(temp_is_negative), .temp_is_zero(temp_is_zero),
    .register0_is_zero(register0_is_zero),
    .write_reg_file(h_write_reg_file), .result_mux_select(h_result_mux_select),
    .op1_mux_select(h_op1_mux_select), .op2_mux_select(h_op2_mux_select),
    .start_delay_counter(h_start_delay_counter), .enable_delay_counter(h_enable_delay_counter),
    .commit_branch(h_commit_branch), .increment_pc(h_increment_pc), .alu_add_sub(h_alu_add_sub),
    .alu_set_low(h_alu_set_low), .alu_set_high(h_alu_set_high), .load_temp(h_load_temp),
    .increment_temp(h_increment_temp), .decrement_temp(h_decrement_temp),
    .select_immediate(h_select_immediate), .select_write_address(h_select_write_address),
    .halted(h_halted)
  );

  int checks = 0;
  int errors = 0;

  // Expected control word in the same bit order as outs (halted = 0).
  function automatic logic [20:0] exp_vec(
    input logic wr, input logic [1:0] o1, input logic [1:0] o2,
    input logic st, input logic en, input logic cb, input logic ip,
    input logic as, input logic sl, input logic sh,
    input logic lt, input logic it, input logic dt,
    input logic [1:0] im, input logic [1:0] wa);
    return {wr, 1'b0, o1, o2, st, en, cb, ip, as, sl, sh, lt, it, dt, im, wa, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flags = 12'h0;
    tick();
    tick();
    #1;
    checks++;
    if (outs !== ZERO_VEC || h_outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL reset_hold: got %h / %h expected %h", outs, h_outs, ZERO_VEC);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO_VEC || h_outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL reset_fetch: got %h / %h expected %h", outs, h_outs, ZERO_VEC);
    end
  endtask

  task automatic test_addi();
    logic [20:0] exp;
    exp = exp_vec(1, OP1_REG, OP2_IMM, 0, 0, 0, 1, ADD, 0, 0, 0, 0, 0, IMM_ARITH, WA_FIELD0);
    tick();
    flags = FL_ADDI;
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL addi_decode: got %h expected %h", outs, exp);
    end
    tick();
    flags = 12'h0;
    #1;
    checks++;
    if (outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL addi_fetch: got %h expected %h", outs, ZERO_VEC);
    end
  endtask

  task automatic test_brz();
    logic [20:0] exp_nt, exp_t;
    exp_nt = exp_vec(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_t  = exp_vec(0, OP1_PC, OP2_IMM, 0, 0, 1, 0, ADD, 0, 0, 0, 0, 0, IMM_BRANCH, 2'b00);
    for (int k = 0; k < 3; k++) begin
      tick();
      // brz not taken, brz taken, then unconditional br with r0 nonzero
      flags = (k == 2) ? FL_BR : FL_BRZ;
      register0_is_zero = (k == 1);
      #1;
      checks++;
      if (outs !== ((k == 0) ? exp_nt : exp_t)) begin
        errors++;
        $display("FAIL branch_%0d: got %h expected %h", k, outs, (k == 0) ? exp_nt : exp_t);
      end
      tick();
      flags = 12'h0;
      register0_is_zero = 1'b0;
      #1;
      checks++;
      if (outs !== ZERO_VEC) begin
        errors++;
        $display("FAIL branch_fetch_%0d: got %h expected %h", k, outs, ZERO_VEC);
      end
    end
  endtask

  task automatic test_simple_ops();
    logic [11:0] t_flag [0:5];
    logic [20:0] t_exp  [0:5];
    logic [20:0] exp_done;
    t_flag[0] = FL_SUBI;
    t_exp[0]  = exp_vec(1, OP1_REG, OP2_IMM, 0, 0, 0, 1, SUB, 0, 0, 0, 0, 0, IMM_ARITH, WA_FIELD0);
    t_flag[1] = FL_SR0;
    t_exp[1]  = exp_vec(1, OP1_R0, OP2_IMM, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, IMM_NIBBLE, WA_R0);
    t_flag[2] = FL_SRH0;
    t_exp[2]  = exp_vec(1, OP1_R0, OP2_IMM, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, IMM_NIBBLE, WA_R0);
    t_flag[3] = FL_CLR;
    t_exp[3]  = exp_vec(1, OP1_REG, OP2_ZERO, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2'b00, WA_FIELD0);
    t_flag[4] = FL_MOV;
    t_exp[4]  = exp_vec(1, OP1_REG, OP2_ZERO, 0, 0, 0, 1, ADD, 0, 0, 0, 0, 0, 2'b00, WA_FIELD1);
    t_flag[5] = FL_MOVA;
    t_exp[5]  = exp_vec(1, OP1_REG, OP2_ZERO, 1, 0, 0, 0, ADD, 0, 0, 0, 0, 0, 2'b00, WA_POS);
    exp_done  = exp_vec(0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) begin
      tick();
      flags = t_flag[i];
      #1;
      checks++;
      if (outs !== t_exp[i]) begin
        errors++;
        $display("FAIL op_decode_%0d: got %h expected %h", i, outs, t_exp[i]);
      end
      if (t_flag[i] == FL_MOVA) begin
        tick();
        flags = 12'h0;
        delay_done = 1'b1;
        #1;
        checks++;
        if (outs !== exp_done) begin
          errors++;
          $display("FAIL mova_wait: got %h expected %h", outs, exp_done);
        end
      end
      tick();
      flags = 12'h0;
      delay_done = 1'b0;
      #1;
      checks++;
      if (outs !== ZERO_VEC) begin
        errors++;
        $display("FAIL op_fetch_%0d: got %h expected %h", i, outs, ZERO_VEC);
      end
    end
  endtask

  // Bench acts as the datapath: holds temp and a delay counter and reacts to
  // the controller's strobes at each edge.
  task automatic test_move(input logic half, input int init, input int nsteps);
    int temp_m, cnt, writes, decs, incs, starts, done_at;
    logic neg;
    logic [20:0] exp_step, exp_wait, exp_end, exp_load;
    neg      = (init < 0);
    exp_load = exp_vec(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
    exp_step = exp_vec(1, OP1_POS, OP2_IMM, 1, 0, 0, 0, neg ? SUB : ADD, 0, 0, 0,
                       neg, !neg, half ? IMM_STEP1 : IMM_STEP2, WA_POS);
    exp_wait = exp_vec(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_end  = exp_vec(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    writes = 0; decs = 0; incs = 0; starts = 0; done_at = -1; cnt = -1;
    tick();
    flags = half ? FL_MOVRHS : FL_MOVR;
    #1;
    checks++;
    if (outs !== exp_load) begin
      errors++;
      $display("FAIL move_load: got %h expected %h", outs, exp_load);
    end
    temp_m = init;
    tick();
    flags = 12'h0;
    for (int cyc = 2; cyc < 200; cyc++) begin
      temp_is_positive = (temp_m > 0);
      temp_is_negative = (temp_m < 0);
      temp_is_zero     = (temp_m == 0);
      delay_done       = (cnt == 0);
      #1;
      if (write_reg_file) writes++;
      if (decrement_temp) decs++;
      if (increment_temp) incs++;
      if (start_delay_counter) starts++;
      if (increment_pc) begin
        done_at = cyc;
        checks++;
        if (outs !== exp_end) begin
          errors++;
          $display("FAIL move_end: got %h expected %h", outs, exp_end);
        end
        break;
      end
      checks++;
      if (outs !== (start_delay_counter ? exp_step : exp_wait)) begin
        errors++;
        $display("FAIL move_cycle_%0d: got %h expected %h", cyc, outs,
                 start_delay_counter ? exp_step : exp_wait);
      end
      if (decrement_temp) temp_m--;
      if (increment_temp) temp_m++;
      if (start_delay_counter) cnt = WAIT_CYCLES - 1;
      else if (cnt > 0) cnt--;
      tick();
    end
    checks++;
    if (done_at != 2 + nsteps * (1 + WAIT_CYCLES)) begin
      errors++;
      $display("FAIL move_latency: got cycle %0d expected %0d", done_at,
               2 + nsteps * (1 + WAIT_CYCLES));
    end
    checks++;
    if (writes != nsteps || starts != nsteps || decs != (neg ? 0 : nsteps) ||
        incs != (neg ? nsteps : 0)) begin
      errors++;
      $display("FAIL move_counts: got w%0d s%0d d%0d i%0d expected steps %0d neg %0b",
               writes, starts, decs, incs, nsteps, neg);
    end
    tick();
    delay_done = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL move_fetch: got %h expected %h", outs, ZERO_VEC);
    end
  endtask

  task automatic test_pause();
    logic [20:0] exp_start, exp_wait, exp_done, exp_addi;
    exp_start = exp_vec(0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_wait  = exp_vec(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_done  = exp_vec(0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_addi  = exp_vec(1, OP1_REG, OP2_IMM, 0, 0, 0, 1, ADD, 0, 0, 0, 0, 0, IMM_ARITH, WA_FIELD0);
    tick();
    flags = FL_PAUSE;
    #1;
    checks++;
    if (outs !== exp_start) begin
      errors++;
      $display("FAIL pause_start: got %h expected %h", outs, exp_start);
    end
    for (int w = 0; w < 3; w++) begin
      tick();
      flags = 12'h0;
      delay_done = (w == 2);
      #1;
      checks++;
      if (outs !== ((w == 2) ? exp_done : exp_wait)) begin
        errors++;
        $display("FAIL pause_wait_%0d: got %h expected %h", w, outs,
                 (w == 2) ? exp_done : exp_wait);
      end
    end
    tick();
    delay_done = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL pause_fetch: got %h expected %h", outs, ZERO_VEC);
    end
    // Second pause, aborted by reset while waiting.
    tick();
    flags = FL_PAUSE;
    tick();
    flags = 12'h0;
    #1;
    checks++;
    if (outs !== exp_wait) begin
      errors++;
      $display("FAIL abort_wait: got %h expected %h", outs, exp_wait);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL abort_reset_cycle: got %h expected %h", outs, ZERO_VEC);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL abort_fetch: got %h expected %h", outs, ZERO_VEC);
    end
    tick();
    flags = FL_ADDI;
    #1;
    checks++;
    if (outs !== exp_addi) begin
      errors++;
      $display("FAIL abort_next_decode: got %h expected %h", outs, exp_addi);
    end
    tick();
    flags = 12'h0;
    #1;
  endtask

  task automatic test_illegal();
    logic [20:0] exp_nop;
    exp_nop = exp_vec(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    // Two flags at once.
    tick();
    flags = FL_BR | FL_ADDI;
    #1;
    checks++;
    if (outs !== exp_nop || h_outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL illegal_multi_decode: got %h / %h expected %h / %h",
               outs, h_outs, exp_nop, ZERO_VEC);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      flags = (i % 2 == 0) ? 12'h0 : FL_ADDI;
      #1;
      checks++;
      if (h_outs !== HALTED_VEC) begin
        errors++;
        $display("FAIL halt_hold_%0d: got %h expected %h", i, h_outs, HALTED_VEC);
      end
    end
    reset = 1'b1;
    flags = 12'h0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (h_outs !== ZERO_VEC || outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL halt_reset: got %h / %h expected %h", outs, h_outs, ZERO_VEC);
    end
    // No flags at all.
    tick();
    flags = 12'h0;
    #1;
    checks++;
    if (outs !== exp_nop || h_outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL illegal_none_decode: got %h / %h expected %h / %h",
               outs, h_outs, exp_nop, ZERO_VEC);
    end
    tick();
    #1;
    checks++;
    if (h_outs !== HALTED_VEC || outs !== ZERO_VEC) begin
      errors++;
      $display("FAIL illegal_none_after: got %h / %h expected %h / %h",
               outs, h_outs, ZERO_VEC, HALTED_VEC);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_addi();
    test_brz();
    test_simple_ops();
    test_move(1'b0, 3, 3);
    test_move(1'b0, -2, 2);
    test_move(1'b1, 0, 0);
    test_move(1'b1, 1, 1);
    test_pause();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time in case the controller stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
